// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - two-stage carry-look-ahead add/subtract with signed saturation
module pipelined_cla_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int HALF = WIDTH / 2;
  localparam int NGRP = HALF / GROUP;

  // One look-ahead group: every internal carry is a flat generate/propagate
  // product of the group inputs and the group carry-in, no ripple inside.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] x,
                                               input logic [GROUP-1:0] y,
                                               input logic c0);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             t;
    logic             u;
    g = x & y;
    p = x ^ y;
    c = '0;
    c[0] = c0;
    for (int i = 1; i <= GROUP; i++) begin
      t = c0;
      for (int k = 0; k < i; k++) t = t & p[k];
      for (int j = 0; j < i; j++) begin
        u = g[j];
        for (int k = j + 1; k < i; k++) u = u & p[k];
        t = t | u;
      end
      c[i] = t;
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  // One half of the datapath: group carries ripple from group to group.
  function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic c0);
    logic [HALF-1:0] s;
    logic            c;
    logic [GROUP:0]  r;
    s = '0;
    c = c0;
    for (int k = 0; k < NGRP; k++) begin
      r = cla_group(x[k*GROUP +: GROUP], y[k*GROUP +: GROUP], c);
      s[k*GROUP +: GROUP] = r[GROUP-1:0];
      c = r[GROUP];
    end
    return {c, s};
  endfunction

  // Stage 1 registers: low-half result, mid carry, upper operand halves
  logic            r_s1_valid;
  logic [HALF-1:0] r_s1_lo;
  logic            r_s1_c_mid;
  logic [HALF-1:0] r_s1_a_hi;
  logic [HALF-1:0] r_s1_b_hi;
  logic            r_s1_sat_op;

  // Stage 2 registers drive the outputs directly
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_ci;
  logic [HALF:0]    w_lo;
  logic [HALF:0]    w_hi;
  logic [WIDTH-1:0] w_raw;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_final;
  logic             w_s2_load;
  logic             w_s1_adv;
  logic             w_in_ready;

  // SUB is a + ~b + ~borrow, so cin=0 on a SUB gives a plain a-b
  assign w_b_eff = b ^ {WIDTH{op[0]}};
  assign w_ci    = cin ^ op[0];
  assign w_lo    = cla_half(a[HALF-1:0], w_b_eff[HALF-1:0], w_ci);

  assign w_hi   = cla_half(r_s1_a_hi, r_s1_b_hi, r_s1_c_mid);
  assign w_raw  = {w_hi[HALF-1:0], r_s1_lo};
  assign w_cout = w_hi[HALF];
  assign w_ovf  = (r_s1_a_hi[HALF-1] == r_s1_b_hi[HALF-1]) &&
                  (w_raw[WIDTH-1] != r_s1_a_hi[HALF-1]);

  // Saturation direction follows the sign of operand A
  always_comb begin
    w_final = w_raw;
    if (r_s1_sat_op && w_ovf) begin
      w_final = r_s1_a_hi[HALF-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign w_s2_load  = !r_out_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_load;
  assign w_in_ready = !r_s1_valid || w_s1_adv;
  assign in_ready   = w_in_ready;

  // Stage 1: capture low-half result whenever the stage can take a beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_lo     <= '0;
      r_s1_c_mid  <= 1'b0;
      r_s1_a_hi   <= '0;
      r_s1_b_hi   <= '0;
      r_s1_sat_op <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_lo     <= w_lo[HALF-1:0];
        r_s1_c_mid  <= w_lo[HALF];
        r_s1_a_hi   <= a[WIDTH-1:HALF];
        r_s1_b_hi   <= w_b_eff[WIDTH-1:HALF];
        r_s1_sat_op <= op[1];
      end
    end
  end

  // Stage 2: finish upper half and flags; hold everything while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_final;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_zero <= (w_final == '0);
        r_neg  <= w_final[WIDTH-1];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - scoreboard bench for pipelined_cla_addsub at WIDTH 32 and 16
module tb_pipelined_cla_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv32, ir32, ov32, or32, cin32, co32, of32, z32, n32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, s32;

  logic        iv16, ir16, ov16, or16, cin16, co16, of16, z16, n16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, s16;

  pipelined_cla_addsub #(.WIDTH(32), .GROUP(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .cin(cin32), .op(op32),
    .out_valid(ov32), .out_ready(or32), .sum(s32),
    .cout(co32), .ovf(of32), .zero(z32), .neg(n32)
  );

  pipelined_cla_addsub #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(cin16), .op(op16),
    .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .ovf(of16), .zero(z16), .neg(n16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] q32[$];
  logic [35:0] q16[$];
  logic [35:0] pend32, pend16;
  logic        acc32, acc16, stall32, stall16;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: packed {sum[31:0], cout, ovf, zero, neg}
  function automatic logic [35:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic [1:0] op);
    logic [63:0] mask, be, full, raw, s;
    logic        am, bm, rm, ovr, co;
    mask = (64'd1 << w) - 64'd1;
    be   = (op[0] ? {32'd0, ~b} : {32'd0, b}) & mask;
    full = {32'd0, a} + be + (op[0] ? {63'd0, ~cin} : {63'd0, cin});
    raw  = full & mask;
    co   = full[w];
    am   = a[w-1];
    bm   = be[w-1];
    rm   = raw[w-1];
    ovr  = (am == bm) && (rm != am);
    s    = raw;
    if (op[1] && ovr) s = am ? (64'd1 << (w - 1)) : (mask >> 1);
    return {s[31:0], co, ovr, (s == 64'd0), s[w-1]};
  endfunction

  function automatic logic [35:0] exp_pack(input logic [31:0] s, input logic co, input logic ovr);
    return {s, co, ovr, (s == 32'd0), s[31]};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock: score both handshakes with settled inputs, then cross the edge
  task automatic tick();
    #1;
    acc32 = 1'b0;
    acc16 = 1'b0;
    if (!rst_n) begin
      q32.delete();
      q16.delete();
      stall32 = 1'b0;
      stall16 = 1'b0;
    end else begin
      check("rdy32", 64'(ir32), 64'(!(q32.size() == 2 && !or32)));
      if (stall32) check("hold32", 64'(ov32), 64'd1);
      if (q32.size() == 0) check("spur32", 64'(ov32), 64'd0);
      else if (ov32) begin
        check("res32", 64'({s32, co32, of32, z32, n32}), 64'(q32[0]));
        if (or32) void'(q32.pop_front());
      end
      stall32 = ov32 && !or32;
      if (iv32 && ir32) begin
        q32.push_back(pend32);
        acc32 = 1'b1;
      end

      check("rdy16", 64'(ir16), 64'(!(q16.size() == 2 && !or16)));
      if (stall16) check("hold16", 64'(ov16), 64'd1);
      if (q16.size() == 0) check("spur16", 64'(ov16), 64'd0);
      else if (ov16) begin
        check("res16", 64'({16'd0, s16, co16, of16, z16, n16}), 64'(q16[0]));
        if (or16) void'(q16.pop_front());
      end
      stall16 = ov16 && !or16;
      if (iv16 && ir16) begin
        q16.push_back(pend16);
        acc16 = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [1:0] o, input logic [35:0] e);
    a32 = a; b32 = b; cin32 = c; op32 = o; pend32 = e;
    iv32 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc32) break;
    end
    check("acc32", 64'(acc32), 64'd1);
    iv32 = 1'b0;
  endtask

  task automatic send32_model(input logic [31:0] a, input logic [31:0] b, input logic c,
                              input logic [1:0] o);
    send32(a, b, c, o, model(32, a, b, c, o));
  endtask

  task automatic drain();
    iv32 = 1'b0; iv16 = 1'b0; or32 = 1'b1; or16 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (q32.size() == 0 && q16.size() == 0) break;
      tick();
    end
    check("drain32", 64'(q32.size()), 64'd0);
    check("drain16", 64'(q16.size()), 64'd0);
  endtask

  initial begin
    int sent;
    rst_n = 1'b0;
    iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; op32 = 2'd0;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; op16 = 2'd0;
    pend32 = '0; pend16 = '0; acc32 = 1'b0; acc16 = 1'b0; stall32 = 1'b0; stall16 = 1'b0;
    @(negedge clk);
    iv32 = 1'b1;
    tick();
    tick();
    iv32 = 1'b0;
    check("rst_outs32", 64'({ov32, s32, co32, of32, z32, n32}), 64'd0);
    check("rst_outs16", 64'({ov16, s16, co16, of16, z16, n16}), 64'd0);
    rst_n = 1'b1;
    check("rst_rdy32", 64'(ir32), 64'd1);

    // Directed corner cases with fixed expected values
    or32 = 1'b1;
    send32(32'hFFFFFFFF, 32'h1, 1'b0, 2'd0, exp_pack(32'h0, 1'b1, 1'b0));
    check("lat_s1", 64'(ov32), 64'd0);
    tick();
    check("lat_s2", 64'(ov32), 64'd1);
    send32(32'd5, 32'd7, 1'b0, 2'd1, exp_pack(32'hFFFFFFFE, 1'b0, 1'b0));
    send32(32'd7, 32'd5, 1'b1, 2'd1, exp_pack(32'h1, 1'b1, 1'b0));
    send32(32'h7FFFFFFF, 32'h1, 1'b0, 2'd2, exp_pack(32'h7FFFFFFF, 1'b0, 1'b1));
    send32(32'h80000000, 32'h1, 1'b0, 2'd3, exp_pack(32'h80000000, 1'b1, 1'b1));
    send32(32'h7FFFFFFF, 32'h1, 1'b0, 2'd0, exp_pack(32'h80000000, 1'b0, 1'b1));
    send32(32'h1, 32'h2, 1'b1, 2'd0, exp_pack(32'h4, 1'b0, 1'b0));
    send32(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 2'd3, exp_pack(32'h7FFFFFFF, 1'b0, 1'b1));
    send32(32'h3, 32'h4, 1'b0, 2'd2, exp_pack(32'h7, 1'b0, 1'b0));
    drain();

    // Eight back-to-back beats with a downstream stall in cycles 3..6
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      if (sent == 8 && c > 7) break;
      or32 = !(c >= 3 && c <= 6);
      iv32 = (sent < 8);
      if (iv32) begin
        a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); op32 = 2'($urandom);
        pend32 = model(32, a32, b32, cin32, op32);
      end
      tick();
      if (acc32) sent++;
    end
    iv32 = 1'b0;
    check("b2b_sent", 64'(sent), 64'd8);
    drain();

    // Reset with two beats in flight and a beat offered during reset
    or32 = 1'b0;
    send32_model(32'h12345678, 32'h11111111, 1'b0, 2'd0);
    send32_model(32'h0000FFFF, 32'h00000001, 1'b0, 2'd1);
    check("inflight", 64'(q32.size()), 64'd2);
    a32 = 32'hDEADBEEF; iv32 = 1'b1; pend32 = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    iv32 = 1'b0;
    check("rst_ov32", 64'(ov32), 64'd0);
    check("rst_ir32", 64'(ir32), 64'd1);
    or32 = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    drain();

    // Random ops and handshakes on the 16-bit instance
    for (int i = 0; i < 10000; i++) begin
      iv16  = ($urandom_range(0, 3) != 0);
      or16  = ($urandom_range(0, 3) != 0);
      a16   = rnd16();
      b16   = rnd16();
      cin16 = 1'($urandom);
      op16  = 2'($urandom);
      pend16 = model(16, {16'd0, a16}, {16'd0, b16}, cin16, op16);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
